// File: rtl/ndn_fib_lookup.sv
// Pipelined NDN FIB exact-name lookup: name hash, then one BST level per stage over a
// heap-organised tree held in per-level registers.
module ndn_fib_lookup #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned POINTER_SIZE    = 16,
    parameter int unsigned MAX_NAME_LENGTH = 8,
    parameter int unsigned TREE_HEIGHT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WORD_SIZE-1:0]    next_name_in [MAX_NAME_LENGTH],
    input  logic                    cfg_we,
    input  logic [TREE_HEIGHT-1:0]  cfg_addr,
    input  logic [WORD_SIZE-1:0]    cfg_key,
    input  logic [POINTER_SIZE-1:0] cfg_ptr,
    input  logic                    cfg_node_valid,
    output logic                    out_valid,
    output logic                    out_hit,
    output logic [POINTER_SIZE-1:0] out_ptr
);

    logic [WORD_SIZE-1:0] name_hash;

    always_comb begin
        name_hash = '0;
        for (int k = 0; k < int'(MAX_NAME_LENGTH); k++) begin
            name_hash = {name_hash[WORD_SIZE-6:0], name_hash[WORD_SIZE-1:WORD_SIZE-5]}
                        ^ next_name_in[k];
        end
    end

    // p_*[s] is the lookup state entering level s; n_*[s] is the state leaving it.
    logic                    p_valid [TREE_HEIGHT];
    logic [WORD_SIZE-1:0]    p_hash  [TREE_HEIGHT];
    logic [TREE_HEIGHT-1:0]  p_idx   [TREE_HEIGHT];
    logic                    p_done  [TREE_HEIGHT];
    logic                    p_hit   [TREE_HEIGHT];
    logic [POINTER_SIZE-1:0] p_ptr   [TREE_HEIGHT];

    logic                    n_valid [TREE_HEIGHT];
    logic [WORD_SIZE-1:0]    n_hash  [TREE_HEIGHT];
    logic [TREE_HEIGHT-1:0]  n_idx   [TREE_HEIGHT];
    logic                    n_done  [TREE_HEIGHT];
    logic                    n_hit   [TREE_HEIGHT];
    logic [POINTER_SIZE-1:0] n_ptr   [TREE_HEIGHT];

    logic                    lvl_vld [TREE_HEIGHT];
    logic [WORD_SIZE-1:0]    lvl_key [TREE_HEIGHT];
    logic [POINTER_SIZE-1:0] lvl_ptr [TREE_HEIGHT];

    for (genvar s = 0; s < int'(TREE_HEIGHT); s++) begin : g_level
        if (s == 0) begin : g_root
            logic                    vld_q;
            logic [WORD_SIZE-1:0]    key_q;
            logic [POINTER_SIZE-1:0] ptr_q;
            logic                    wr_sel;

            assign wr_sel = cfg_we && (cfg_addr == TREE_HEIGHT'(1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (wr_sel) begin
                    vld_q <= cfg_node_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (wr_sel) begin
                    key_q <= cfg_key;
                    ptr_q <= cfg_ptr;
                end
            end

            assign lvl_vld[s] = vld_q;
            assign lvl_key[s] = key_q;
            assign lvl_ptr[s] = ptr_q;
        end else begin : g_inner
            logic [2**s-1:0]         vld_q;
            logic [WORD_SIZE-1:0]    key_q [2**s];
            logic [POINTER_SIZE-1:0] ptr_q [2**s];
            logic                    wr_sel;
            logic [s-1:0]            wr_off;
            logic [s-1:0]            rd_off;

            // Level s nodes have bit s as their leading one; the low bits pick the slot.
            assign wr_sel = cfg_we && ((cfg_addr >> s) == TREE_HEIGHT'(1));
            assign wr_off = cfg_addr[s-1:0];
            assign rd_off = p_idx[s][s-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else if (wr_sel) begin
                    vld_q[wr_off] <= cfg_node_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (wr_sel) begin
                    key_q[wr_off] <= cfg_key;
                    ptr_q[wr_off] <= cfg_ptr;
                end
            end

            assign lvl_vld[s] = vld_q[rd_off];
            assign lvl_key[s] = key_q[rd_off];
            assign lvl_ptr[s] = ptr_q[rd_off];
        end
    end

    always_comb begin
        for (int s = 0; s < int'(TREE_HEIGHT); s++) begin
            n_valid[s] = p_valid[s];
            n_hash[s]  = p_hash[s];
            n_idx[s]   = p_idx[s];
            n_done[s]  = p_done[s];
            n_hit[s]   = p_hit[s];
            n_ptr[s]   = p_ptr[s];
            if (!p_done[s]) begin
                if (!lvl_vld[s]) begin
                    n_done[s] = 1'b1;
                end else if (lvl_key[s] == p_hash[s]) begin
                    n_done[s] = 1'b1;
                    n_hit[s]  = 1'b1;
                    n_ptr[s]  = lvl_ptr[s];
                end else if (p_hash[s] < lvl_key[s]) begin
                    n_idx[s] = p_idx[s] << 1;
                end else begin
                    n_idx[s] = (p_idx[s] << 1) | TREE_HEIGHT'(1);
                end
            end
        end
    end

    // Only valid/hit/ptr matter after the last level; an unfinished lookup has hit=0, ptr=0.
    logic unused_final;
    assign unused_final = ^{n_hash[TREE_HEIGHT-1], n_idx[TREE_HEIGHT-1], n_done[TREE_HEIGHT-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(TREE_HEIGHT); s++) begin
                p_valid[s] <= 1'b0;
                p_hash[s]  <= '0;
                p_idx[s]   <= '0;
                p_done[s]  <= 1'b0;
                p_hit[s]   <= 1'b0;
                p_ptr[s]   <= '0;
            end
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_ptr   <= '0;
        end else begin
            p_valid[0] <= in_valid;
            p_hash[0]  <= name_hash;
            p_idx[0]   <= TREE_HEIGHT'(1);
            p_done[0]  <= 1'b0;
            p_hit[0]   <= 1'b0;
            p_ptr[0]   <= '0;
            for (int s = 1; s < int'(TREE_HEIGHT); s++) begin
                p_valid[s] <= n_valid[s-1];
                p_hash[s]  <= n_hash[s-1];
                p_idx[s]   <= n_idx[s-1];
                p_done[s]  <= n_done[s-1];
                p_hit[s]   <= n_hit[s-1];
                p_ptr[s]   <= n_ptr[s-1];
            end
            out_valid <= n_valid[TREE_HEIGHT-1];
            out_hit   <= n_valid[TREE_HEIGHT-1] && n_hit[TREE_HEIGHT-1];
            out_ptr   <= (n_valid[TREE_HEIGHT-1] && n_hit[TREE_HEIGHT-1]) ?
                         n_ptr[TREE_HEIGHT-1] : '0;
        end
    end

endmodule

// File: tb/tb_ndn_fib_lookup.sv
// Directed self-checking bench for ndn_fib_lookup: latency, hits/misses, deep paths,
// back-to-back streaming and reset flush.
module tb_ndn_fib_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] name_in [8];
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_key;
    logic [15:0] cfg_ptr;
    logic        cfg_node_valid;
    logic        out_valid;
    logic        out_hit;
    logic [15:0] out_ptr;

    int vectors = 0;
    int miscompares = 0;

    ndn_fib_lookup dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .next_name_in   (name_in),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_key        (cfg_key),
        .cfg_ptr        (cfg_ptr),
        .cfg_node_valid (cfg_node_valid),
        .out_valid      (out_valid),
        .out_hit        (out_hit),
        .out_ptr        (out_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_name(input logic [31:0] w0, input logic [31:0] w6,
                            input logic [31:0] w7);
        for (int k = 0; k < 8; k++) name_in[k] = 32'h0;
        name_in[0] = w0;
        name_in[6] = w6;
        name_in[7] = w7;
    endtask

    // Called on a negedge; the write lands on the following posedge.
    task automatic write_node(input logic [3:0] a, input logic [31:0] k, input logic [15:0] p,
                              input logic v);
        cfg_we = 1'b1; cfg_addr = a; cfg_key = k; cfg_ptr = p; cfg_node_valid = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Single lookup with exact latency check: no output at 4 cycles, result at 5.
    task automatic lookup(input string tag, input logic [31:0] w0, input logic [31:0] w7,
                          input logic eh, input logic [15:0] ep);
        set_name(w0, 32'h0, w7);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".early"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(out_valid), 32'h1);
        check({tag, ".hit"}, 32'(out_hit), 32'(eh));
        check({tag, ".ptr"}, 32'(out_ptr), 32'(ep));
    endtask

    logic [31:0] s_hash [9];
    logic        s_hit  [9];
    logic [15:0] s_ptr  [9];
    int          stale;

    initial begin
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_key = '0;
        cfg_ptr = '0; cfg_node_valid = 1'b0;
        set_name(32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset.valid", 32'(out_valid), 32'h0);
        check("reset.hit", 32'(out_hit), 32'h0);
        check("reset.ptr", 32'(out_ptr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Empty tree: name {1,0,...} hashes to 0x8 and misses.
        lookup("empty", 32'h1, 32'h0, 1'b0, 16'h0000);

        write_node(4'd1, 32'h8, 16'h00AA, 1'b1);
        lookup("root_hit", 32'h1, 32'h0, 1'b1, 16'h00AA);

        write_node(4'd2, 32'h5, 16'h00BB, 1'b1);
        lookup("left_hit", 32'h0, 32'h5, 1'b1, 16'h00BB);
        lookup("right_inv", 32'h0, 32'h9, 1'b0, 16'h0000);

        // Address 0 must be ignored.
        write_node(4'd0, 32'h9, 16'hFFFF, 1'b1);
        lookup("addr0", 32'h0, 32'h9, 1'b0, 16'h0000);

        // Left spine 1->2->4->8.
        write_node(4'd1, 32'h40, 16'h0001, 1'b1);
        write_node(4'd2, 32'h20, 16'h0002, 1'b1);
        write_node(4'd4, 32'h10, 16'h0004, 1'b1);
        write_node(4'd8, 32'h08, 16'h0123, 1'b1);
        lookup("deep_hit", 32'h0, 32'h8, 1'b1, 16'h0123);
        lookup("mid_hit", 32'h0, 32'h20, 1'b1, 16'h0002);
        lookup("past_leaf", 32'h0, 32'h4, 1'b0, 16'h0000);
        write_node(4'd8, 32'h08, 16'h0123, 1'b0);
        lookup("deleted", 32'h0, 32'h8, 1'b0, 16'h0000);
        write_node(4'd8, 32'h08, 16'h0123, 1'b1);

        // Back-to-back stream; entries 1 and 3 use names whose hash comes from rotation.
        s_hash = '{32'h40, 32'h20, 32'h10, 32'h08, 32'h50, 32'h30, 32'h04, 32'h18, 32'h40};
        s_hit  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        s_ptr  = '{16'h0001, 16'h0002, 16'h0004, 16'h0123, 16'h0, 16'h0, 16'h0, 16'h0,
                   16'h0001};
        for (int j = 0; j < 14; j++) begin
            if (j == 4) check("stream.pre", 32'(out_valid), 32'h0);
            if (j >= 5) begin
                check($sformatf("stream%0d.valid", j - 5), 32'(out_valid), 32'h1);
                check($sformatf("stream%0d.hit", j - 5), 32'(out_hit), 32'(s_hit[j-5]));
                check($sformatf("stream%0d.ptr", j - 5), 32'(out_ptr), 32'(s_ptr[j-5]));
            end
            if (j < 9) begin
                if (j == 1) set_name(32'h0, 32'h1, 32'h0);
                else if (j == 3) set_name(32'h1, 32'h0, 32'h0);
                else set_name(32'h0, 32'h0, s_hash[j]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream.post", 32'(out_valid), 32'h0);

        // Reset with one result showing and more lookups still in flight.
        for (int j = 0; j < 6; j++) begin
            set_name(32'h0, 32'h0, 32'h40);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("flush.pre_valid", 32'(out_valid), 32'h1);
        check("flush.pre_hit", 32'(out_hit), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("flush.valid", 32'(out_valid), 32'h0);
        check("flush.hit", 32'(out_hit), 32'h0);
        check("flush.ptr", 32'(out_ptr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("flush.stale", 32'(stale), 32'h0);
        lookup("flush.empty", 32'h0, 32'h40, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
